// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from Commit against the L2 TLB and cp0_group,
// snapshotting the CP0 TLB registers at acceptance and flushing the L1 TLBs after writes.
module tlb_op_sequencer #(
    parameter int TLB_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    output logic        op_ready,
    output logic        op_done,
    input  logic [5:0]  cp0_index,
    input  logic [5:0]  cp0_random,
    input  logic [31:0] cp0_entryhi,
    input  logic [31:0] cp0_entrylo0,
    input  logic [31:0] cp0_entrylo1,
    input  logic [15:0] cp0_pagemask,
    output logic        tlbp_en,
    output logic        tlbr_en,
    output logic        l2_qry_req,
    output logic [18:0] l2_qry_vpn2,
    output logic [7:0]  l2_qry_asid,
    input  logic        l2_qry_done,
    output logic        l2_rd_req,
    output logic [5:0]  l2_rd_index,
    input  logic        l2_rd_valid,
    output logic        l2_wr_en,
    output logic [5:0]  l2_wr_index,
    output logic [78:0] l2_wr_data,
    output logic [15:0] l2_wr_pagemask,
    input  logic        l2_ready,
    output logic        l1_flush
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        READ,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [18:0]       vpn2_q;
    logic [7:0]        asid_q;
    logic [25:0]       lo0_q, lo1_q;
    logic [15:0]       pagemask_q;
    logic [5:0]        idx_q;
    logic [CNT_W-1:0]  flushCnt_q;
    logic              opReady_q, opDone_q, tlbpEn_q, qryReq_q, rdReq_q, flush_q;

    logic              accept;
    logic [5:0]        acceptIdx;
    logic [5:0]        targetIdx;
    logic              idxOk;
    logic              unusedBits;

    function automatic logic inRange(input logic [5:0] idx);
        return int'(idx) < TLB_ENTRIES;
    endfunction

    // TLBWR takes its slot from Random, and only the value seen in the accept cycle counts.
    assign accept     = (state_q == IDLE) && op_valid;
    assign acceptIdx  = (op_type == OP_TLBWR) ? cp0_random : cp0_index;
    assign targetIdx  = accept ? acceptIdx : idx_q;
    assign idxOk      = inRange(idx_q);
    assign unusedBits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    if (op_type == OP_TLBP)      state_d = PROBE;
                    else if (op_type == OP_TLBR) state_d = READ;
                    else                         state_d = WRITE;
                end
            end
            PROBE:   if (l2_qry_done)               state_d = DONE;
            READ:    if (!idxOk || l2_rd_valid)     state_d = DONE;
            WRITE:   if (!idxOk || l2_ready)        state_d = FLUSH;
            FLUSH:   if (flushCnt_q == CNT_W'(1))   state_d = DONE;
            DONE:                                   state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Level outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vpn2_q     <= '0;
            asid_q     <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            pagemask_q <= '0;
            idx_q      <= '0;
            flushCnt_q <= '0;
            opReady_q  <= 1'b1;
            opDone_q   <= 1'b0;
            tlbpEn_q   <= 1'b0;
            qryReq_q   <= 1'b0;
            rdReq_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                vpn2_q     <= cp0_entryhi[31:13];
                asid_q     <= cp0_entryhi[7:0];
                lo0_q      <= cp0_entrylo0[25:0];
                lo1_q      <= cp0_entrylo1[25:0];
                pagemask_q <= cp0_pagemask;
                idx_q      <= acceptIdx;
            end
            if (state_q != FLUSH && state_d == FLUSH) begin
                flushCnt_q <= FLUSH_LOAD;
            end else if (state_q == FLUSH) begin
                flushCnt_q <= flushCnt_q - CNT_W'(1);
            end
            opReady_q <= (state_d == IDLE);
            opDone_q  <= (state_d == DONE);
            tlbpEn_q  <= (state_d == PROBE);
            qryReq_q  <= (state_d == PROBE);
            rdReq_q   <= (state_d == READ) && inRange(targetIdx);
            flush_q   <= (state_d == FLUSH);
        end
    end

    assign op_ready       = opReady_q;
    assign op_done        = opDone_q;
    assign tlbp_en        = tlbpEn_q;
    assign l2_qry_req     = qryReq_q;
    assign l2_qry_vpn2    = vpn2_q;
    assign l2_qry_asid    = asid_q;
    assign l2_rd_req      = rdReq_q;
    assign l2_rd_index    = idx_q;
    assign l1_flush       = flush_q;
    assign l2_wr_index    = idx_q;
    assign l2_wr_data     = {vpn2_q, asid_q, lo1_q, lo0_q};
    assign l2_wr_pagemask = pagemask_q;

    // cp0_group samples the read data in the very cycle the L2 TLB returns it.
    assign tlbr_en  = (state_q == READ) && l2_rd_valid && idxOk;
    assign l2_wr_en = (state_q == WRITE) && l2_ready && idxOk;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Scoreboard bench for tlb_op_sequencer: a 64-entry and a 32-entry instance share all inputs
// and run in lockstep; a negedge monitor pops expected completions and writes from queues.
module tb_tlb_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [5:0]  cp0_index, cp0_random;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic [15:0] cp0_pagemask;
    logic        l2_qry_done, l2_rd_valid, l2_ready;

    logic        op_ready, op_done, tlbp_en, tlbr_en, l2_qry_req, l2_rd_req, l2_wr_en, l1_flush;
    logic [18:0] l2_qry_vpn2;
    logic [7:0]  l2_qry_asid;
    logic [5:0]  l2_rd_index, l2_wr_index;
    logic [78:0] l2_wr_data;
    logic [15:0] l2_wr_pagemask;

    logic        op_ready32, op_done32, tlbp_en32, tlbr_en32, l2_qry_req32, l2_rd_req32, l2_wr_en32, l1_flush32;
    logic [18:0] l2_qry_vpn232;
    logic [7:0]  l2_qry_asid32;
    logic [5:0]  l2_rd_index32, l2_wr_index32;
    logic [78:0] l2_wr_data32;
    logic [15:0] l2_wr_pagemask32;

    tlb_op_sequencer dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .op_done(op_done),
        .cp0_index(cp0_index), .cp0_random(cp0_random), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_pagemask(cp0_pagemask),
        .tlbp_en(tlbp_en), .tlbr_en(tlbr_en),
        .l2_qry_req(l2_qry_req), .l2_qry_vpn2(l2_qry_vpn2), .l2_qry_asid(l2_qry_asid),
        .l2_qry_done(l2_qry_done),
        .l2_rd_req(l2_rd_req), .l2_rd_index(l2_rd_index), .l2_rd_valid(l2_rd_valid),
        .l2_wr_en(l2_wr_en), .l2_wr_index(l2_wr_index), .l2_wr_data(l2_wr_data),
        .l2_wr_pagemask(l2_wr_pagemask), .l2_ready(l2_ready), .l1_flush(l1_flush)
    );

    tlb_op_sequencer #(.TLB_ENTRIES(32), .FLUSH_CYCLES(2)) dut32 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready32), .op_done(op_done32),
        .cp0_index(cp0_index), .cp0_random(cp0_random), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_pagemask(cp0_pagemask),
        .tlbp_en(tlbp_en32), .tlbr_en(tlbr_en32),
        .l2_qry_req(l2_qry_req32), .l2_qry_vpn2(l2_qry_vpn232), .l2_qry_asid(l2_qry_asid32),
        .l2_qry_done(l2_qry_done),
        .l2_rd_req(l2_rd_req32), .l2_rd_index(l2_rd_index32), .l2_rd_valid(l2_rd_valid),
        .l2_wr_en(l2_wr_en32), .l2_wr_index(l2_wr_index32), .l2_wr_data(l2_wr_data32),
        .l2_wr_pagemask(l2_wr_pagemask32), .l2_ready(l2_ready), .l1_flush(l1_flush32)
    );

    typedef struct {
        int          doneCyc;
        int          tlbpCyc;
        int          tlbrCyc;
        int          rdReqCyc;
        int          wrCyc;
        int          flushCyc;
        int          wrCyc32;
        int          tlbrCyc32;
        int          flushCyc32;
        bit          chkQry;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        bit          chkRd;
        logic [5:0]  rdIdx;
    } doneExp_t;

    typedef struct {
        logic [5:0]  idx;
        logic [78:0] data;
        logic [15:0] pm;
    } wrExp_t;

    doneExp_t expDone[$];
    wrExp_t   expWr[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          tlbpCnt, qryCnt, tlbrCnt, rdReqCnt, wrCnt, flushCnt, wrCnt32, tlbrCnt32, flushCnt32;
    logic [18:0] vpnSeen;
    logic [7:0]  asidSeen;
    logic [5:0]  rdIdxSeen;
    bit          prevDone;
    doneExp_t    monE;
    wrExp_t      monW;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic doneExp_t blankExp(input int doneCyc);
        doneExp_t e;
        e.doneCyc = doneCyc;
        e.tlbpCyc = 0; e.tlbrCyc = 0; e.rdReqCyc = 0; e.wrCyc = 0; e.flushCyc = 0;
        e.wrCyc32 = 0; e.tlbrCyc32 = 0; e.flushCyc32 = 0;
        e.chkQry = 0; e.vpn2 = '0; e.asid = '0; e.chkRd = 0; e.rdIdx = '0;
        return e;
    endfunction

    function automatic logic [78:0] expData(input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        return {hi[31:13], hi[7:0], lo1[25:0], lo0[25:0]};
    endfunction

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseInput(input int at, input bit isRead);
        waitUntil(at);
        if (isRead) l2_rd_valid = 1'b1; else l2_qry_done = 1'b1;
        @(posedge clk);
        #1;
        l2_rd_valid = 1'b0;
        l2_qry_done = 1'b0;
    endtask

    // Presents one op for one cycle and then scrambles CP0 so only the snapshot can be used.
    task automatic applyStimulus(input logic [1:0] typ, input logic [5:0] idx, input logic [5:0] rnd,
                                 input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1,
                                 input logic [15:0] pm, output int acceptCyc);
        int budget = 0;
        while (!op_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!op_ready) checkOutput("op_ready wait", op_ready, 1);
        op_valid     = 1'b1;
        op_type      = typ;
        cp0_index    = idx;
        cp0_random   = rnd;
        cp0_entryhi  = hi;
        cp0_entrylo0 = lo0;
        cp0_entrylo1 = lo1;
        cp0_pagemask = pm;
        acceptCyc    = cyc;
        @(posedge clk);
        #1;
        op_valid     = 1'b0;
        cp0_index    = ~idx;
        cp0_random   = 6'd0;
        cp0_entryhi  = ~hi;
        cp0_entrylo0 = ~lo0;
        cp0_entrylo1 = ~lo1;
        cp0_pagemask = ~pm;
    endtask

    initial begin
        prevDone = 0;
        tlbpCnt = 0; qryCnt = 0; tlbrCnt = 0; rdReqCnt = 0; wrCnt = 0; flushCnt = 0;
        wrCnt32 = 0; tlbrCnt32 = 0; flushCnt32 = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                tlbpCnt = 0; qryCnt = 0; tlbrCnt = 0; rdReqCnt = 0; wrCnt = 0; flushCnt = 0;
                wrCnt32 = 0; tlbrCnt32 = 0; flushCnt32 = 0;
                prevDone = 0;
            end else begin
                if (tlbp_en) tlbpCnt++;
                if (l2_qry_req) qryCnt++;
                if (l2_rd_req) rdReqCnt++;
                if (l1_flush) flushCnt++;
                if (l1_flush32) flushCnt32++;
                if (l2_wr_en32) wrCnt32++;
                if (tlbr_en32) tlbrCnt32++;
                if (tlbr_en) begin
                    tlbrCnt++;
                    rdIdxSeen = l2_rd_index;
                end
                if (tlbp_en && l2_qry_done) begin
                    vpnSeen  = l2_qry_vpn2;
                    asidSeen = l2_qry_asid;
                end
                if (l2_wr_en) begin
                    wrCnt++;
                    checkOutput("l2_wr_en expected", expWr.size() > 0, 1);
                    if (expWr.size() > 0) begin
                        monW = expWr.pop_front();
                        checkOutput("l2_wr_index", l2_wr_index, monW.idx);
                        checkOutput("l2_wr_data", l2_wr_data, monW.data);
                        checkOutput("l2_wr_pagemask", l2_wr_pagemask, monW.pm);
                    end
                end
                if (prevDone) checkOutput("op_ready after done", op_ready, 1);
                if (op_done || op_done32) checkOutput("dut32 op_done lockstep", op_done32, op_done);
                if (op_done) begin
                    checkOutput("op_ready during done", op_ready, 0);
                    checkOutput("op_done expected", expDone.size() > 0, 1);
                    if (expDone.size() > 0) begin
                        monE = expDone.pop_front();
                        checkOutput("op_done cycle", cyc, monE.doneCyc);
                        checkOutput("tlbp_en cycles", tlbpCnt, monE.tlbpCyc);
                        checkOutput("l2_qry_req cycles", qryCnt, monE.tlbpCyc);
                        checkOutput("tlbr_en cycles", tlbrCnt, monE.tlbrCyc);
                        checkOutput("l2_rd_req cycles", rdReqCnt, monE.rdReqCyc);
                        checkOutput("l2_wr_en cycles", wrCnt, monE.wrCyc);
                        checkOutput("l1_flush cycles", flushCnt, monE.flushCyc);
                        checkOutput("dut32 l2_wr_en cycles", wrCnt32, monE.wrCyc32);
                        checkOutput("dut32 tlbr_en cycles", tlbrCnt32, monE.tlbrCyc32);
                        checkOutput("dut32 l1_flush cycles", flushCnt32, monE.flushCyc32);
                        if (monE.chkQry) begin
                            checkOutput("l2_qry_vpn2", vpnSeen, monE.vpn2);
                            checkOutput("l2_qry_asid", asidSeen, monE.asid);
                        end
                        if (monE.chkRd) checkOutput("l2_rd_index", rdIdxSeen, monE.rdIdx);
                    end
                    tlbpCnt = 0; qryCnt = 0; tlbrCnt = 0; rdReqCnt = 0; wrCnt = 0; flushCnt = 0;
                    wrCnt32 = 0; tlbrCnt32 = 0; flushCnt32 = 0;
                end
                prevDone = op_done;
            end
        end
    end

    initial begin
        int t;
        doneExp_t e;
        logic [31:0] hiTab [3];
        logic [31:0] hi, lo0, lo1;
        hiTab[0] = 32'h8000_3FC1;
        hiTab[1] = 32'h1234_5F02;
        hiTab[2] = 32'hFFFF_E0FF;

        reset = 1'b1; op_valid = 1'b0; op_type = 2'b00;
        cp0_index = '0; cp0_random = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_pagemask = '0;
        l2_qry_done = 1'b0; l2_rd_valid = 1'b0; l2_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset op_ready", op_ready, 1);
        checkOutput("reset op_done", op_done, 0);
        checkOutput("reset tlbp_en", tlbp_en, 0);
        checkOutput("reset l2_qry_req", l2_qry_req, 0);
        checkOutput("reset l2_rd_req", l2_rd_req, 0);
        checkOutput("reset l2_wr_en", l2_wr_en, 0);
        checkOutput("reset l1_flush", l1_flush, 0);
        checkOutput("reset l2_wr_data", l2_wr_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] TLBP with done 4 cycles after accept");
        hi = {19'h12345, 5'b1_0110, 8'h3A};
        applyStimulus(2'b00, 6'd7, 6'd20, hi, 32'h0, 32'h0, 16'h0, t);
        e = blankExp(t + 5);
        e.tlbpCyc = 4; e.chkQry = 1; e.vpn2 = 19'h12345; e.asid = 8'h3A;
        expDone.push_back(e);
        pulseInput(t + 4, 1'b0);
        waitUntil(t + 7);
        l2_qry_done = 1'b1;
        l2_rd_valid = 1'b1;
        @(posedge clk);
        #1;
        l2_qry_done = 1'b0;
        l2_rd_valid = 1'b0;

        $display("[TB] TLBR index 17, valid 2 cycles after request");
        applyStimulus(2'b01, 6'd17, 6'd30, 32'hABCD_E055, 32'h0, 32'h0, 16'h0, t);
        e = blankExp(t + 4);
        e.tlbrCyc = 1; e.tlbrCyc32 = 1; e.rdReqCyc = 3; e.chkRd = 1; e.rdIdx = 6'd17;
        expDone.push_back(e);
        pulseInput(t + 3, 1'b1);
        waitUntil(t + 5);

        $display("[TB] TLBWI index 5 with l2_ready low for 3 cycles");
        l2_ready = 1'b0;
        hi = {19'h04F1A, 5'b0, 8'h21};
        applyStimulus(2'b10, 6'd5, 6'd12, hi, 32'h0000_1F07, 32'h0000_2F07, 16'h1800, t);
        expWr.push_back('{6'd5, {19'h04F1A, 8'h21, 26'h000_2F07, 26'h000_1F07}, 16'h1800});
        e = blankExp(t + 7);
        e.wrCyc = 1; e.wrCyc32 = 1; e.flushCyc = 2; e.flushCyc32 = 2;
        expDone.push_back(e);
        waitUntil(t + 4);
        l2_ready = 1'b1;
        pulseInput(t + 5, 1'b1);
        waitUntil(t + 8);

        $display("[TB] TLBWR with Random 40, 39, 38 (out of range for 32 entries)");
        for (int i = 0; i < 3; i++) begin
            lo0 = 32'hFC00_0100 + 32'(i);
            lo1 = 32'h03FF_FFF0 - 32'(i);
            applyStimulus(2'b11, 6'd2, 6'(40 - i), hiTab[i], lo0, lo1, 16'h0006 + 16'(i), t);
            expWr.push_back('{6'(40 - i), expData(hiTab[i], lo0, lo1), 16'h0006 + 16'(i)});
            e = blankExp(t + 4);
            e.wrCyc = 1; e.wrCyc32 = 0; e.flushCyc = 2; e.flushCyc32 = 2;
            expDone.push_back(e);
            waitUntil(t + 5);
        end

        $display("[TB] reset during PROBE");
        applyStimulus(2'b00, 6'd1, 6'd1, 32'h0000_2001, 32'h0, 32'h0, 16'h0, t);
        waitUntil(t + 2);
        checkOutput("probe active before reset", tlbp_en, 1);
        reset = 1'b1;
        #1;
        checkOutput("abort tlbp_en", tlbp_en, 0);
        checkOutput("abort l2_qry_req", l2_qry_req, 0);
        checkOutput("abort op_ready", op_ready, 1);
        checkOutput("abort op_done", op_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitUntil(cyc + 3);

        $display("[TB] reset during FLUSH");
        hi = {19'h7_0F0F, 5'b0, 8'h99};
        applyStimulus(2'b10, 6'd3, 6'd44, hi, 32'h0000_0ABC, 32'h0000_0DEF, 16'h0000, t);
        expWr.push_back('{6'd3, expData(hi, 32'h0000_0ABC, 32'h0000_0DEF), 16'h0000});
        waitUntil(t + 2);
        checkOutput("flush active before reset", l1_flush, 1);
        reset = 1'b1;
        #1;
        checkOutput("abort l1_flush", l1_flush, 0);
        checkOutput("abort op_ready after flush", op_ready, 1);
        checkOutput("abort op_done after flush", op_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitUntil(cyc + 4);

        $display("[TB] TLBR index 9 after reset, valid immediately");
        applyStimulus(2'b01, 6'd9, 6'd50, 32'h0, 32'h0, 32'h0, 16'h0, t);
        e = blankExp(t + 2);
        e.tlbrCyc = 1; e.tlbrCyc32 = 1; e.rdReqCyc = 1; e.chkRd = 1; e.rdIdx = 6'd9;
        expDone.push_back(e);
        pulseInput(t + 1, 1'b1);
        waitUntil(t + 5);

        checkOutput("pending op_done expectations", expDone.size(), 0);
        checkOutput("pending l2 write expectations", expWr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlb_op_sequencer.md
Name: tlb_op_sequencer

Overview:
Sequences the TLBP/TLBR/TLBWI/TLBWR instructions issued by Commit against the L2 TLB and the CP0 register group. For TLBP it holds the probe enable until the L2 TLB query completes. For TLBR it produces the one-cycle CP0 update strobe. For TLBWI/TLBWR it snapshots the CP0 EntryHi/EntryLo0/EntryLo1/PageMask/Index/Random values, writes the L2 TLB and flushes the L1 I/D TLBs. It sits between Commit, cp0_group and the L2 TLB.

Parameters:
TLB_ENTRIES, 64, number of L2 TLB entries; indices >= TLB_ENTRIES are out of range
FLUSH_CYCLES, 2, length of the l1_flush assertion after a write (minimum 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
op_valid  in  1  Commit requests a TLB op
op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_ready  out  1  sequencer idle; the op is accepted on op_valid & op_ready
op_done  out  1  one-cycle completion pulse
cp0_index  in  6  CP0 Index.index
cp0_random  in  6  CP0 Random
cp0_entryhi  in  32  {VPN2[31:13], 5'b0, ASID[7:0]}
cp0_entrylo0  in  32  EntryLo0; bits [25:0] used
cp0_entrylo1  in  32  EntryLo1; bits [25:0] used
cp0_pagemask  in  16  PageMask raw value
tlbp_en  out  1  to cp0_group; held through the probe
tlbr_en  out  1  to cp0_group; one-cycle strobe
l2_qry_req  out  1  L2 probe request
l2_qry_vpn2  out  19  probe VPN2
l2_qry_asid  out  8  probe ASID
l2_qry_done  in  1  probe complete, one cycle
l2_rd_req  out  1  L2 read-by-index request
l2_rd_index  out  6  read index
l2_rd_valid  in  1  read data valid, one cycle
l2_wr_en  out  1  L2 write strobe
l2_wr_index  out  6  write index
l2_wr_data  out  79  {VPN2[78:60], ASID[59:52], Lo1[51:26], Lo0[25:0]}
l2_wr_pagemask  out  16  write PageMask
l2_ready  in  1  L2 can accept a write this cycle
l1_flush  out  1  invalidate the L1 I/D TLBs

Behaviour:
- States: IDLE, PROBE, READ, WRITE, FLUSH, DONE. Reset (asynchronous) forces IDLE, zeroes the snapshot registers and the flush counter, and drops all outputs to 0 except op_ready=1.
- op_ready = (state==IDLE). op_valid while not ready is ignored; Commit holds it.
- On acceptance, snapshot EntryHi, Lo0[25:0], Lo1[25:0], PageMask and the target index. Target index = cp0_index for TLBR/TLBWI and cp0_random for TLBWR. Random is sampled in the accept cycle only. All later outputs come from the snapshot.
- IDLE -> PROBE/READ/WRITE by op_type (TLBWI and TLBWR both go to WRITE).
- PROBE: tlbp_en=1 and l2_qry_req=1 continuously; vpn2/asid are taken from the snapshot. In the cycle l2_qry_done=1, tlbp_en is still 1 (cp0_group samples tlbp_en & done), and the next state is DONE.
- READ: l2_rd_req=1 until l2_rd_valid. tlbr_en = READ & l2_rd_valid, combinational and same cycle. Next state is DONE.
- READ with an out-of-range index: no l2_rd_req and no tlbr_en; go straight to DONE.
- WRITE: l2_wr_en = WRITE & l2_ready. Go to FLUSH on l2_ready, or immediately if the index is out of range (write suppressed).
- FLUSH: l1_flush=1 for exactly FLUSH_CYCLES cycles (down-counter), then DONE.
- DONE: op_done=1 for one cycle, op_ready=0; next state is IDLE.
- Latency from the accept cycle T:
  - TLBP: done pulse at D+1, where D is the l2_qry_done cycle.
  - TLBR: done pulse at V+1, where V is the l2_rd_valid cycle.
  - TLBWI/WR with l2_ready held high: l2_wr_en at T+1, l1_flush T+2..T+1+FLUSH_CYCLES, op_done at T+2+FLUSH_CYCLES.
- Stray l2_qry_done or l2_rd_valid outside PROBE/READ is ignored.
- A CP0 change after acceptance does not affect the op in flight.
- Reset asserted mid-operation aborts immediately: no op_done pulse, and any partial flush is abandoned.

Test Plan:
- TLBP, VPN2=0x12345, ASID=0x3A, l2_qry_done 4 cycles after accept -> tlbp_en high 4 cycles including the done cycle; op_done 1 cycle later; op_ready returns the next cycle.
- TLBR, index 17, l2_rd_valid 2 cycles after l2_rd_req -> l2_rd_index=17; tlbr_en exactly one cycle, coincident with valid; then op_done.
- TLBWI, index 5, Lo0=0x0000_1F07, Lo1=0x0000_2F07, l2_ready low for 3 cycles -> l2_wr_en exactly one cycle, on the first ready cycle; l2_wr_data[25:0]=0x1F07, [51:26]=0x2F07; l1_flush exactly 2 cycles; then op_done.
- TLBWR with cp0_random decrementing 40,39,38 across accept cycles -> l2_wr_index equals the Random value of the accept cycle.
- TLBWR, TLB_ENTRIES=32, random=40 -> no l2_wr_en; l1_flush still FLUSH_CYCLES cycles; op_done asserted.
- Reset asserted during PROBE and during FLUSH -> tlbp_en/l1_flush drop immediately; no op_done; op_ready=1; the next op executes normally.
